cbm_step_sequencer: RTL and testbench
=====================================

Name: cbm_step_sequencer

Overview:
- Sequences the recurrent CBM neuron datapath over one input sample at a time.
- Per accepted input sample, issues NSUB step tokens toward the accumulate path, one outstanding at a time.
- Collects the NH-bit CbmState returned for each step and integrates a per-neuron firing count.
- After the last step, emits the counts as the time-averaged hidden vector to the readout; the first NWASH samples are washout and produce no output.

Parameters:
- NH, 8, number of hidden neurons.
- WIN, 16, input sample data width.
- NSUB, 16, sub-steps per input sample (>=1).
- NWASH, 4, washout samples whose hidden output is dropped (>=0).
- WC, $clog2(NSUB+1), per-neuron count width (derived; not overridable).

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- iValid_AS_Input  in  1  input sample valid.
- oReady_AS_Input  out  1  input sample ready.
- iData_AS_Input  in  WIN  input sample.
- oValid_BS_Step  out  1  step token valid.
- iReady_BS_Step  in  1  step token ready.
- oData_BS_Step  out  WIN+2  {first, last, sample}: first=1 on step 0, last=1 on step NSUB-1.
- iValid_AM_CbmState  in  1  returned neuron state valid.
- oReady_AM_CbmState  out  1  returned neuron state ready.
- iData_AM_CbmState  in  NH  binary neuron states for the completed step.
- oValid_BM_Hidden  out  1  hidden vector valid.
- iReady_BM_Hidden  in  1  hidden vector ready.
- oData_BM_Hidden  out  NH*WC  neuron i count at bits [i*WC +: WC].
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, release on a clock edge):
  - state=IDLE; all valids 0; oReady_AS_Input=0 for the first cycle after release; oBusy=0.
  - Step counter, washout counter, count registers and sample register all cleared to 0.
  - Asserting iRST mid-operation aborts the sample; the outstanding CbmState may be discarded.
- State IDLE:
  - oReady_AS_Input=1.
  - On a handshake, latch the sample, clear all counts, step=0, go to ISSUE.
- State ISSUE:
  - oValid_BS_Step=1; data is held stable until the handshake.
  - On handshake go to WAIT.
  - Latency from input handshake to step valid is 1 cycle.
- State WAIT:
  - oReady_AM_CbmState=1.
  - On handshake: count[i] += iData_AM_CbmState[i] for every i, saturating at NSUB (unreachable by construction; assertion only).
  - If step==NSUB-1, go to EMIT; else step++ and go to ISSUE.
- At most one step outstanding. oReady_AM_CbmState=0 outside WAIT; a CbmState valid outside WAIT is held off and is never counted.
- State EMIT:
  - If the washout counter < NWASH: increment it, assert no valid, go to IDLE next cycle.
  - Otherwise: oValid_BM_Hidden=1 with counts held until handshake, then go to IDLE.
  - The washout counter saturates at NWASH.
- No input sample is accepted while busy (no pipelining across samples). Back-to-back samples therefore take at least 2*NSUB+2 cycles each.
- Ready and valid signals are registered; no combinational path from any iReady/iValid to any oValid/oReady.
- NSUB=1: first=last=1 on the single token.
- NWASH=0: every sample emits.

Decomposition:
- Shared package/header holds:
  - State encoding: IDLE=0, ISSUE=1, WAIT=2, EMIT=3.
  - WC derivation.
  - Step token field offsets: FIRST=WIN+1, LAST=WIN.
- One natural sub-module, cbm_fire_counter: NH parallel WC-bit counters with clear and enable, NH-bit increment vector, flattened count output.

Test Plan:
- NSUB=4, NWASH=0; CbmState returns 8'hFF,8'h01,8'h00,8'h81 -> hidden counts n0=3, n7=2, n1..n6=1; oData_BM_Hidden matches packing.
- Step token framing, NSUB=4, sample 16'h1234 -> four tokens; first/last = 10,00,00,01; sample field always 16'h1234.
- NWASH=2, five samples with all-ones CbmState -> exactly 3 hidden outputs, each count=NSUB; the first two samples return to IDLE without valid.
- Backpressure: iReady_BS_Step and iReady_BM_Hidden held low 10 cycles -> outputs stable, no lost or duplicated token. A spurious CbmState valid asserted during ISSUE is not accepted.
- Reset in WAIT at step 2 -> all valids 0 immediately. The next sample starts with step 0, first=1, counts cleared, and the washout counter restarts from 0.
- NSUB=1 -> a single token with first=last=1; counts are 0 or 1 and equal the returned state bits.

Source files
------------

// File: rtl/cbm_step_sequencer_pkg.sv
// Shared types and helpers for the CBM step sequencer: FSM encoding,
// count width derivation and step token field positions.
package cbm_step_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } seq_state_e;

  // A count can reach NSUB, so it needs room for NSUB+1 values.
  function automatic int cbm_wc(input int nsub);
    return $clog2(nsub + 1);
  endfunction

  function automatic int step_first_bit(input int win);
    return win + 1;
  endfunction

  function automatic int step_last_bit(input int win);
    return win;
  endfunction

endpackage

// File: rtl/cbm_step_sequencer_if.sv
// Handshake bundle between the step sequencer and its neighbours:
// sample input, step token output, CbmState return and hidden vector output.
interface cbm_step_sequencer_if
  import cbm_step_sequencer_pkg::*;
#(
  parameter int NH   = 8,
  parameter int WIN  = 16,
  parameter int NSUB = 16
) ();
  localparam int WC = cbm_wc(NSUB);

  logic                 iValid_AS_Input;
  logic                 oReady_AS_Input;
  logic [WIN-1:0]       iData_AS_Input;

  logic                 oValid_BS_Step;
  logic                 iReady_BS_Step;
  logic [WIN+1:0]       oData_BS_Step;

  logic                 iValid_AM_CbmState;
  logic                 oReady_AM_CbmState;
  logic [NH-1:0]        iData_AM_CbmState;

  logic                 oValid_BM_Hidden;
  logic                 iReady_BM_Hidden;
  logic [NH*WC-1:0]     oData_BM_Hidden;

  modport slave (
    input  iValid_AS_Input, iData_AS_Input,
    output oReady_AS_Input,
    output oValid_BS_Step, oData_BS_Step,
    input  iReady_BS_Step,
    input  iValid_AM_CbmState, iData_AM_CbmState,
    output oReady_AM_CbmState,
    output oValid_BM_Hidden, oData_BM_Hidden,
    input  iReady_BM_Hidden
  );

  modport master (
    output iValid_AS_Input, iData_AS_Input,
    input  oReady_AS_Input,
    input  oValid_BS_Step, oData_BS_Step,
    output iReady_BS_Step,
    output iValid_AM_CbmState, iData_AM_CbmState,
    input  oReady_AM_CbmState,
    input  oValid_BM_Hidden, oData_BM_Hidden,
    output iReady_BM_Hidden
  );

endinterface

// File: rtl/cbm_step_sequencer_fire_counter.sv
// NH parallel saturating firing counters; clear wins over enable, and each
// enabled counter adds its bit of the increment vector.
module cbm_fire_counter
  import cbm_step_sequencer_pkg::*;
#(
  parameter  int NH   = 8,
  parameter  int NSUB = 16,
  localparam int WC   = cbm_wc(NSUB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [NH-1:0]    inc,
  output logic [NH*WC-1:0] count
);

  localparam logic [WC-1:0] SAT = WC'(NSUB);

  for (genvar gi = 0; gi < NH; gi++) begin : g_cnt
    logic [WC-1:0] cnt_q;
    logic [WC-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en && inc[gi] && (cnt_q != SAT)) begin
        cnt_d = cnt_q + WC'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign count[gi*WC +: WC] = cnt_q;

    // One increment per sub-step means saturation should never be hit.
    a_no_sat: assert property (@(posedge clk) disable iff (rst)
      !(en && !clr && inc[gi] && (cnt_q == SAT)));
  end

endmodule

// File: rtl/cbm_step_sequencer.sv
// Per-sample step sequencer for the recurrent CBM datapath: issues NSUB step
// tokens one at a time, integrates returned states, emits counts after washout.
module cbm_step_sequencer
  import cbm_step_sequencer_pkg::*;
#(
  parameter int NH    = 8,
  parameter int WIN   = 16,
  parameter int NSUB  = 16,
  parameter int NWASH = 4
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  cbm_step_sequencer_if.slave  bus,
  output logic                 oBusy
);

  localparam int WC        = cbm_wc(NSUB);
  localparam int SW        = $clog2(NSUB + 1);
  localparam int WW        = $clog2(NWASH + 2);
  localparam int FIRST_BIT = step_first_bit(WIN);
  localparam int LAST_BIT  = step_last_bit(WIN);
  localparam logic [SW-1:0] LAST_STEP = SW'(NSUB - 1);
  localparam logic [WW-1:0] WASH_MAX  = WW'(NWASH);

  seq_state_e      state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [WW-1:0]   wash_q, wash_d;
  logic [WIN-1:0]  sample_q, sample_d;
  logic            in_ready_q, in_ready_d;
  logic            step_valid_q, step_valid_d;
  logic            cbm_ready_q, cbm_ready_d;
  logic            hid_valid_q, hid_valid_d;
  logic            busy_q, busy_d;
  logic            cnt_clr;
  logic            cnt_en;
  logic [WIN+1:0]  step_tok;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    wash_d   = wash_q;
    sample_d = sample_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_ready_q && bus.iValid_AS_Input) begin
          sample_d = bus.iData_AS_Input;
          step_d   = '0;
          cnt_clr  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (step_valid_q && bus.iReady_BS_Step) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cbm_ready_q && bus.iValid_AM_CbmState) begin
          cnt_en = 1'b1;
          if (step_q == LAST_STEP) begin
            state_d = ST_EMIT;
          end else begin
            step_d  = step_q + SW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_EMIT: begin
        if (!hid_valid_q) begin
          if (wash_q < WASH_MAX) begin
            wash_d = wash_q + WW'(1);
          end
          state_d = ST_IDLE;
        end else if (bus.iReady_BM_Hidden) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are decoded from the next state so they leave as flops.
    in_ready_d   = (state_d == ST_IDLE);
    step_valid_d = (state_d == ST_ISSUE);
    cbm_ready_d  = (state_d == ST_WAIT);
    hid_valid_d  = (state_d == ST_EMIT) && (wash_d == WASH_MAX);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      wash_q       <= '0;
      sample_q     <= '0;
      in_ready_q   <= 1'b0;
      step_valid_q <= 1'b0;
      cbm_ready_q  <= 1'b0;
      hid_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      wash_q       <= wash_d;
      sample_q     <= sample_d;
      in_ready_q   <= in_ready_d;
      step_valid_q <= step_valid_d;
      cbm_ready_q  <= cbm_ready_d;
      hid_valid_q  <= hid_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    step_tok            = '0;
    step_tok[WIN-1:0]   = sample_q;
    step_tok[FIRST_BIT] = (step_q == '0);
    step_tok[LAST_BIT]  = (step_q == LAST_STEP);
  end

  cbm_fire_counter #(
    .NH   (NH),
    .NSUB (NSUB)
  ) u_fire_counter (
    .clk   (iCLK),
    .rst   (iRST),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .inc   (bus.iData_AM_CbmState),
    .count (bus.oData_BM_Hidden)
  );

  assign bus.oReady_AS_Input    = in_ready_q;
  assign bus.oValid_BS_Step     = step_valid_q;
  assign bus.oData_BS_Step      = step_tok;
  assign bus.oReady_AM_CbmState = cbm_ready_q;
  assign bus.oValid_BM_Hidden   = hid_valid_q;
  assign oBusy                  = busy_q;

endmodule

// File: tb/tb_cbm_step_sequencer.sv
// Directed bench: three sequencer instances (NSUB=4/NWASH=0, NSUB=4/NWASH=2,
// NSUB=1/NWASH=0) share stimulus; sel picks which one a scenario drives.
module tb_cbm_step_sequencer;
  import cbm_step_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic busy_a, busy_b, busy_c;
  logic [1:0]  sel = 2'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        step_ready = 1'b1;
  logic        cbm_valid = 1'b0;
  logic [7:0]  cbm_data = '0;
  logic        hid_ready = 1'b1;

  cbm_step_sequencer_if #(.NH(8), .WIN(16), .NSUB(4)) if_a ();
  cbm_step_sequencer_if #(.NH(8), .WIN(16), .NSUB(4)) if_b ();
  cbm_step_sequencer_if #(.NH(8), .WIN(16), .NSUB(1)) if_c ();

  cbm_step_sequencer #(.NH(8), .WIN(16), .NSUB(4), .NWASH(0)) dut_a (
    .iCLK(clk), .iRST(rst_a), .bus(if_a.slave), .oBusy(busy_a));
  cbm_step_sequencer #(.NH(8), .WIN(16), .NSUB(4), .NWASH(2)) dut_b (
    .iCLK(clk), .iRST(rst_b), .bus(if_b.slave), .oBusy(busy_b));
  cbm_step_sequencer #(.NH(8), .WIN(16), .NSUB(1), .NWASH(0)) dut_c (
    .iCLK(clk), .iRST(rst_c), .bus(if_c.slave), .oBusy(busy_c));

  assign if_a.iValid_AS_Input = in_valid && (sel == 2'd0);
  assign if_b.iValid_AS_Input = in_valid && (sel == 2'd1);
  assign if_c.iValid_AS_Input = in_valid && (sel == 2'd2);
  assign if_a.iData_AS_Input = in_data;
  assign if_b.iData_AS_Input = in_data;
  assign if_c.iData_AS_Input = in_data;
  assign if_a.iReady_BS_Step = step_ready;
  assign if_b.iReady_BS_Step = step_ready;
  assign if_c.iReady_BS_Step = step_ready;
  assign if_a.iValid_AM_CbmState = cbm_valid;
  assign if_b.iValid_AM_CbmState = cbm_valid;
  assign if_c.iValid_AM_CbmState = cbm_valid;
  assign if_a.iData_AM_CbmState = cbm_data;
  assign if_b.iData_AM_CbmState = cbm_data;
  assign if_c.iData_AM_CbmState = cbm_data;
  assign if_a.iReady_BM_Hidden = hid_ready;
  assign if_b.iReady_BM_Hidden = hid_ready;
  assign if_c.iReady_BM_Hidden = hid_ready;

  logic        mon_in_ready, mon_step_valid, mon_cbm_ready, mon_hid_valid, mon_busy;
  logic [17:0] mon_step_data;
  logic [23:0] mon_hid;

  always_comb begin
    mon_in_ready   = if_a.oReady_AS_Input;
    mon_step_valid = if_a.oValid_BS_Step;
    mon_step_data  = if_a.oData_BS_Step;
    mon_cbm_ready  = if_a.oReady_AM_CbmState;
    mon_hid_valid  = if_a.oValid_BM_Hidden;
    mon_hid        = if_a.oData_BM_Hidden;
    mon_busy       = busy_a;
    if (sel == 2'd1) begin
      mon_in_ready   = if_b.oReady_AS_Input;
      mon_step_valid = if_b.oValid_BS_Step;
      mon_step_data  = if_b.oData_BS_Step;
      mon_cbm_ready  = if_b.oReady_AM_CbmState;
      mon_hid_valid  = if_b.oValid_BM_Hidden;
      mon_hid        = if_b.oData_BM_Hidden;
      mon_busy       = busy_b;
    end else if (sel == 2'd2) begin
      mon_in_ready   = if_c.oReady_AS_Input;
      mon_step_valid = if_c.oValid_BS_Step;
      mon_step_data  = if_c.oData_BS_Step;
      mon_cbm_ready  = if_c.oReady_AM_CbmState;
      mon_hid_valid  = if_c.oValid_BM_Hidden;
      mon_hid        = {16'h0000, if_c.oData_BM_Hidden};
      mon_busy       = busy_c;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Results captured by run_sample for the scenario tasks to judge.
  logic [7:0]  ret_states [16];
  logic [17:0] tok_data [16];
  int          tok_n, tok_dup, tok_unstable, spur_acc, lat0, hs_cyc;
  logic        hid_seen;
  logic [23:0] hid_data;
  int          hid_unstable, hid_after;

  task automatic run_sample(input logic [15:0] smp, input int nsub, input int bp, input int abort_at);
    int guard;
    logic [17:0] tok;
    tok_n = 0; tok_dup = 0; tok_unstable = 0; spur_acc = 0; lat0 = -1;
    hid_seen = 1'b0; hid_data = '0; hid_unstable = 0; hid_after = 0;
    in_data = smp; in_valid = 1'b1; guard = 0;
    while (!mon_in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    if (!mon_in_ready) begin
      checks++; failures++; in_valid = 1'b0;
      $display("FAIL watchdog_in_ready: got no ready in %0d cycles, required ready", guard);
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; hs_cyc = cyc;
    for (int s = 0; s < nsub; s++) begin
      guard = 0;
      if (s == 0 && bp > 0) begin
        step_ready = 1'b0; cbm_data = 8'hFF; cbm_valid = 1'b1;
      end
      while (!mon_step_valid && guard < 40) begin @(posedge clk); #1; guard++; end
      if (!mon_step_valid) begin
        checks++; failures++; step_ready = 1'b1; cbm_valid = 1'b0;
        $display("FAIL watchdog_step: got no step valid at step %0d, required valid", s);
        return;
      end
      if (s == 0) lat0 = guard;
      tok = mon_step_data;
      if (s == 0 && bp > 0) begin
        for (int k = 0; k < bp; k++) begin
          @(posedge clk); #1;
          if (!mon_step_valid || mon_step_data !== tok) tok_unstable++;
          if (mon_cbm_ready) spur_acc++;
        end
        cbm_valid = 1'b0; step_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (mon_step_valid) tok_dup++;
      tok_data[tok_n] = tok; tok_n++;
      guard = 0;
      while (!mon_cbm_ready && guard < 40) begin @(posedge clk); #1; guard++; end
      if (!mon_cbm_ready) begin
        checks++; failures++;
        $display("FAIL watchdog_cbm_ready: got no ready at step %0d, required ready", s);
        return;
      end
      if (s == abort_at) begin
        if (sel == 2'd1) rst_b = 1'b1; else if (sel == 2'd2) rst_c = 1'b1; else rst_a = 1'b1;
        #1;
        $display("sample %h: aborted by reset at step %0d", smp, s);
        return;
      end
      cbm_data = ret_states[s]; cbm_valid = 1'b1;
      @(posedge clk); #1;
      cbm_valid = 1'b0;
    end
    guard = 0;
    while (guard < 40) begin
      if (mon_hid_valid) begin
        hid_seen = 1'b1; hid_data = mon_hid;
        if (bp > 0) begin
          hid_ready = 1'b0;
          for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            if (!mon_hid_valid || mon_hid !== hid_data) hid_unstable++;
          end
          hid_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (mon_hid_valid) hid_after++;
        break;
      end else if (!mon_busy) begin
        break;
      end
      @(posedge clk); #1; guard++;
    end
    if (guard >= 40) begin
      checks++; failures++;
      $display("FAIL watchdog_emit: still busy after %0d cycles, required return to idle", guard);
    end
    $display("sample %h: tokens=%0d hidden=%0b data=%h", smp, tok_n, hid_seen, hid_data);
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (mon_step_valid !== 1'b0) begin failures++; $display("FAIL rst_step_valid: got %b required 0", mon_step_valid); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    checks++; if (mon_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_first: got %b required 0", mon_in_ready); end
    checks++; if (mon_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", mon_busy); end
    checks++; if (mon_hid_valid !== 1'b0 || mon_cbm_ready !== 1'b0) begin failures++; $display("FAIL rst_valids: got hid=%b cbm_rdy=%b required 0 0", mon_hid_valid, mon_cbm_ready); end
    checks++; if (mon_hid !== 24'h0) begin failures++; $display("FAIL rst_counts: got %h required 000000", mon_hid); end
    @(posedge clk); #1;
    checks++; if (mon_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_idle: got %b required 1", mon_in_ready); end
  endtask

  task automatic test_hidden_counts();
    logic [23:0] exp_h;
    sel = 2'd0;
    exp_h = {3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3};
    ret_states[0] = 8'hFF; ret_states[1] = 8'h01; ret_states[2] = 8'h00; ret_states[3] = 8'h81;
    run_sample(16'hA5A5, 4, 0, -1);
    checks++; if (lat0 !== 0) begin failures++; $display("FAIL step_latency: got %0d extra cycles required 0", lat0); end
    checks++; if (hid_seen !== 1'b1) begin failures++; $display("FAIL counts_emitted: got %b required 1", hid_seen); end
    checks++; if (hid_data !== exp_h) begin failures++; $display("FAIL counts_packing: got %h required %h", hid_data, exp_h); end
    checks++; if (tok_dup !== 0) begin failures++; $display("FAIL counts_tok_dup: got %0d required 0", tok_dup); end
  endtask

  task automatic test_step_framing();
    logic [17:0] exp_t [4];
    sel = 2'd0;
    exp_t[0] = 18'h21234; exp_t[1] = 18'h01234; exp_t[2] = 18'h01234; exp_t[3] = 18'h11234;
    for (int s = 0; s < 4; s++) ret_states[s] = 8'h00;
    run_sample(16'h1234, 4, 0, -1);
    checks++; if (tok_n !== 4) begin failures++; $display("FAIL frame_tok_count: got %0d required 4", tok_n); end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (tok_data[s] !== exp_t[s]) begin failures++; $display("FAIL frame_tok%0d: got %h required %h", s, tok_data[s], exp_t[s]); end
    end
    checks++; if (hid_data !== 24'h0) begin failures++; $display("FAIL frame_counts_cleared: got %h required 000000", hid_data); end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [23:0] h0;
    sel = 2'd0;
    for (int s = 0; s < 4; s++) ret_states[s] = 8'hFF;
    run_sample(16'h0001, 4, 0, -1);
    c0 = hs_cyc; h0 = hid_data;
    run_sample(16'h0002, 4, 0, -1);
    checks++; if (hs_cyc - c0 !== 10) begin failures++; $display("FAIL b2b_period: got %0d cycles required 10", hs_cyc - c0); end
    checks++; if (h0 !== {8{3'd4}}) begin failures++; $display("FAIL b2b_first_counts: got %h required %h", h0, {8{3'd4}}); end
    checks++; if (hid_data !== {8{3'd4}}) begin failures++; $display("FAIL b2b_second_counts: got %h required %h", hid_data, {8{3'd4}}); end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_h;
    sel = 2'd0;
    exp_h = {3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2};
    ret_states[0] = 8'h0F; ret_states[1] = 8'hF0; ret_states[2] = 8'h3C; ret_states[3] = 8'hFF;
    run_sample(16'hBEEF, 4, 10, -1);
    checks++; if (tok_unstable !== 0) begin failures++; $display("FAIL bp_tok_stable: got %0d changes required 0", tok_unstable); end
    checks++; if (spur_acc !== 0) begin failures++; $display("FAIL bp_spurious_ready: got %0d cycles required 0", spur_acc); end
    checks++; if (tok_n !== 4 || tok_dup !== 0) begin failures++; $display("FAIL bp_tok_count: got n=%0d dup=%0d required 4 0", tok_n, tok_dup); end
    checks++; if (tok_data[0] !== 18'h2BEEF) begin failures++; $display("FAIL bp_tok0: got %h required 2beef", tok_data[0]); end
    checks++; if (hid_unstable !== 0) begin failures++; $display("FAIL bp_hid_stable: got %0d changes required 0", hid_unstable); end
    checks++; if (hid_after !== 0) begin failures++; $display("FAIL bp_hid_dup: got %0d required 0", hid_after); end
    checks++; if (hid_data !== exp_h) begin failures++; $display("FAIL bp_counts: got %h required %h", hid_data, exp_h); end
  endtask

  task automatic test_washout();
    int n_out;
    logic exp_seen;
    sel = 2'd1; n_out = 0;
    for (int s = 0; s < 4; s++) ret_states[s] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      run_sample(16'h4000 + 16'(i), 4, 0, -1);
      exp_seen = (i >= 2);
      if (hid_seen) n_out++;
      checks++;
      if (hid_seen !== exp_seen) begin failures++; $display("FAIL wash_emit%0d: got %b required %b", i, hid_seen, exp_seen); end
      if (exp_seen) begin
        checks++;
        if (hid_data !== {8{3'd4}}) begin failures++; $display("FAIL wash_counts%0d: got %h required %h", i, hid_data, {8{3'd4}}); end
      end
    end
    checks++; if (n_out !== 3) begin failures++; $display("FAIL wash_total: got %0d required 3", n_out); end
  endtask

  task automatic test_reset_mid_wait();
    logic exp_seen;
    logic [23:0] exp_h;
    sel = 2'd1;
    for (int s = 0; s < 4; s++) ret_states[s] = 8'hFF;
    run_sample(16'h0F0F, 4, 0, 2);
    checks++; if (rst_b !== 1'b1) begin failures++; $display("FAIL midrst_reached_wait: got %b required 1", rst_b); end
    checks++;
    if (mon_step_valid !== 1'b0 || mon_cbm_ready !== 1'b0 || mon_hid_valid !== 1'b0 || mon_in_ready !== 1'b0 || mon_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got step=%b cbm=%b hid=%b in=%b busy=%b required all 0",
               mon_step_valid, mon_cbm_ready, mon_hid_valid, mon_in_ready, mon_busy);
    end
    rst_b = 1'b0;
    exp_h = {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4};
    for (int s = 0; s < 4; s++) ret_states[s] = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      run_sample(16'h7700 + 16'(i), 4, 0, -1);
      exp_seen = (i == 2);
      checks++;
      if (tok_data[0] !== (18'h20000 | (18'h07700 + 18'(i)))) begin
        failures++; $display("FAIL midrst_first_tok%0d: got %h required %h", i, tok_data[0], 18'h20000 | (18'h07700 + 18'(i)));
      end
      checks++;
      if (hid_seen !== exp_seen) begin failures++; $display("FAIL midrst_wash%0d: got %b required %b", i, hid_seen, exp_seen); end
    end
    checks++; if (hid_data !== exp_h) begin failures++; $display("FAIL midrst_counts: got %h required %h", hid_data, exp_h); end
  endtask

  task automatic test_nsub1();
    sel = 2'd2;
    ret_states[0] = 8'hA6;
    run_sample(16'hC0DE, 1, 0, -1);
    checks++; if (tok_n !== 1 || tok_data[0] !== 18'h3C0DE) begin failures++; $display("FAIL nsub1_tok: got n=%0d %h required 1 3c0de", tok_n, tok_data[0]); end
    checks++; if (hid_data !== 24'h0000A6) begin failures++; $display("FAIL nsub1_counts: got %h required 0000a6", hid_data); end
    ret_states[0] = 8'h18;
    run_sample(16'h0001, 1, 0, -1);
    checks++; if (tok_data[0] !== 18'h30001) begin failures++; $display("FAIL nsub1_tok2: got %h required 30001", tok_data[0]); end
    checks++; if (hid_data !== 24'h000018) begin failures++; $display("FAIL nsub1_counts2: got %h required 000018", hid_data); end
  endtask

  initial begin
    test_reset();
    test_hidden_counts();
    test_step_framing();
    test_back_to_back();
    test_backpressure();
    test_washout();
    test_reset_mid_wait();
    test_nsub1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
